imm_ext_id_ex_reg: RTL and testbench

//  ID->EX pipeline register for the immediate/operand path of the 16-bit pipelined core.

---
 rtl/imm_ext_id_ex_reg.sv | 141 ++++++++++++++
 tb/tb_imm_ext_id_ex_reg.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_ext_id_ex_reg.sv
// ID->EX pipeline register for the immediate/operand path: captures the instruction, operands and extended immediate.
// Optional saturating stall/flush performance counters are built when IMM_PERF_CNT_EN is defined.
module imm_ext_id_ex_reg #(
    parameter int                DATA_W    = 16,
    parameter int                CNT_W     = 16,
    parameter logic [DATA_W-1:0] NOP_INSTR = 16'h0800
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              flush,
    input  logic [DATA_W-1:0] instr,
    input  logic [1:0]        immd_loc,
    input  logic              sign_ext,
    input  logic [DATA_W-1:0] rs_data,
    input  logic [DATA_W-1:0] rt_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_instr,
    output logic [DATA_W-1:0] out_imm,
    output logic [DATA_W-1:0] out_rs,
    output logic [DATA_W-1:0] out_rt,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    // The single-bit field is treated as a flag and is never sign-extended.
    function automatic logic [DATA_W-1:0] extImm(
        input logic [DATA_W-1:0] ins,
        input logic [1:0]        loc,
        input logic              sext
    );
        logic [DATA_W-1:0] res;
        res = {DATA_W{1'b0}};
        case (loc)
            2'b00:   res = {{(DATA_W-5){sext & ins[4]}}, ins[4:0]};
            2'b01:   res = {{(DATA_W-8){sext & ins[7]}}, ins[7:0]};
            2'b10:   res = {{(DATA_W-11){sext & ins[10]}}, ins[10:0]};
            2'b11:   res = {{(DATA_W-1){1'b0}}, ins[0]};
            default: res = {DATA_W{1'b0}};
        endcase
        return res;
    endfunction

    logic              outValid_r;
    logic [DATA_W-1:0] outInstr_r;
    logic [DATA_W-1:0] outImm_r;
    logic [DATA_W-1:0] outRs_r;
    logic [DATA_W-1:0] outRt_r;

    logic              nextValid_s;
    logic [DATA_W-1:0] nextInstr_s;
    logic [DATA_W-1:0] nextImm_s;
    logic [DATA_W-1:0] nextRs_s;
    logic [DATA_W-1:0] nextRt_s;
    logic              inReady_s;

    assign inReady_s = !outValid_r || out_ready;
    assign in_ready  = inReady_s;

    // Next slot contents: flush beats load, load beats drain, otherwise hold.
    always_comb begin
        nextValid_s = outValid_r;
        nextInstr_s = outInstr_r;
        nextImm_s   = outImm_r;
        nextRs_s    = outRs_r;
        nextRt_s    = outRt_r;
        if (flush) begin
            nextValid_s = 1'b0;
            nextInstr_s = NOP_INSTR;
            nextImm_s   = {DATA_W{1'b0}};
        end else if (in_valid && inReady_s) begin
            nextValid_s = 1'b1;
            nextInstr_s = instr;
            nextImm_s   = extImm(instr, immd_loc, sign_ext);
            nextRs_s    = rs_data;
            nextRt_s    = rt_data;
        end else if (out_ready) begin
            nextValid_s = 1'b0;
            nextInstr_s = NOP_INSTR;
        end else begin
            nextValid_s = outValid_r;
            nextInstr_s = outInstr_r;
        end
    end

    // Slot register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            outValid_r <= 1'b0;
            outInstr_r <= NOP_INSTR;
            outImm_r   <= {DATA_W{1'b0}};
            outRs_r    <= {DATA_W{1'b0}};
            outRt_r    <= {DATA_W{1'b0}};
        end else begin
            outValid_r <= nextValid_s;
            outInstr_r <= nextInstr_s;
            outImm_r   <= nextImm_s;
            outRs_r    <= nextRs_s;
            outRt_r    <= nextRt_s;
        end
    end

    assign out_valid = outValid_r;
    assign out_instr = outInstr_r;
    assign out_imm   = outImm_r;
    assign out_rs    = outRs_r;
    assign out_rt    = outRt_r;

`ifdef IMM_PERF_CNT_EN
    logic [CNT_W-1:0] stallCnt_r;
    logic [CNT_W-1:0] flushCnt_r;

    // Saturating counters; only reset clears them.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stallCnt_r <= {CNT_W{1'b0}};
            flushCnt_r <= {CNT_W{1'b0}};
        end else begin
            if (outValid_r && !out_ready && (stallCnt_r != {CNT_W{1'b1}})) begin
                stallCnt_r <= stallCnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                stallCnt_r <= stallCnt_r;
            end
            if (flush && outValid_r && (flushCnt_r != {CNT_W{1'b1}})) begin
                flushCnt_r <= flushCnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                flushCnt_r <= flushCnt_r;
            end
        end
    end

    assign stall_cnt = stallCnt_r;
    assign flush_cnt = flushCnt_r;
`else
    assign stall_cnt = {CNT_W{1'b0}};
    assign flush_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_imm_ext_id_ex_reg.sv
// Self-checking bench for imm_ext_id_ex_reg: scoreboard queue of expected EX-slot contents.
// Counter expectations follow IMM_PERF_CNT_EN.
module tb_imm_ext_id_ex_reg;

    typedef struct packed {
        logic [15:0] instr;
        logic [15:0] imm;
        logic [15:0] rs;
        logic [15:0] rt;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        flush;
    logic [15:0] instr;
    logic [1:0]  immd_loc;
    logic        sign_ext;
    logic [15:0] rs_data;
    logic [15:0] rt_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_instr;
    logic [15:0] out_imm;
    logic [15:0] out_rs;
    logic [15:0] out_rt;
    logic [15:0] stall_cnt;
    logic [15:0] flush_cnt;

    int   checks   = 0;
    int   failures = 0;
    exp_t sbQ[$];

`ifdef IMM_PERF_CNT_EN
    localparam logic [15:0] EXP_STALL = 16'd3;
    localparam logic [15:0] EXP_FLUSH = 16'd1;
`else
    localparam logic [15:0] EXP_STALL = 16'd0;
    localparam logic [15:0] EXP_FLUSH = 16'd0;
`endif

    imm_ext_id_ex_reg dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .flush(flush), .instr(instr), .immd_loc(immd_loc), .sign_ext(sign_ext),
        .rs_data(rs_data), .rt_data(rt_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_instr(out_instr), .out_imm(out_imm),
        .out_rs(out_rs), .out_rt(out_rt), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    // Reference extension: mask the field, then OR in the upper ones when sign-extending.
    function automatic logic [15:0] refExt(input logic [15:0] ins, input logic [1:0] loc, input logic sx);
        int          w;
        logic [15:0] mask;
        logic [15:0] r;
        w    = (loc == 2'd0) ? 5 : (loc == 2'd1) ? 8 : (loc == 2'd2) ? 11 : 1;
        mask = 16'((32'd1 << w) - 32'd1);
        r    = ins & mask;
        if (sx && (loc != 2'd3) && ins[w-1]) r = r | ~mask;
        return r;
    endfunction

    task automatic drive(input logic v, input logic [15:0] ins, input logic [1:0] loc,
                         input logic sx, input logic [15:0] a, input logic [15:0] b);
        in_valid = v; instr = ins; immd_loc = loc; sign_ext = sx; rs_data = a; rt_data = b;
    endtask

    task automatic stepClk();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1;
        drive(1'b0, 16'h0000, 2'd0, 1'b0, 16'h0000, 16'h0000);
        stepClk();
        stepClk();
        checks++;
        if ({out_valid, out_instr, out_imm, out_rs, out_rt} !== {1'b0, 16'h0800, 48'h0}) begin
            failures++;
            $display("FAIL reset_outputs got v=%b i=%h m=%h rs=%h rt=%h want v=0 i=0800 rest 0",
                     out_valid, out_instr, out_imm, out_rs, out_rt);
        end
        checks++;
        if ({stall_cnt, flush_cnt, in_ready} !== {32'h0, 1'b1}) begin
            failures++;
            $display("FAIL reset_counters got stall=%h flush=%h rdy=%b want 0 0 1", stall_cnt, flush_cnt, in_ready);
        end
        rst_n = 1'b1;
        stepClk();
    endtask

    task automatic test_extension();
        logic [15:0] insT[8] = '{16'h5015, 16'h5015, 16'h07FF, 16'h07FF, 16'h07FF, 16'h07FF, 16'h03FF, 16'h0480};
        logic [1:0]  locT[8] = '{2'd0, 2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd2, 2'd1};
        logic        sxT[8]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        exp_t        e;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, insT[i], locT[i], sxT[i], 16'(16'h1000 + i), 16'(16'h2000 + i));
            sbQ.push_back('{insT[i], refExt(insT[i], locT[i], sxT[i]), 16'(16'h1000 + i), 16'(16'h2000 + i)});
            stepClk();
            e = sbQ.pop_front();
            checks++;
            if ({out_valid, out_instr, out_imm, out_rs, out_rt} !== {1'b1, e}) begin
                failures++;
                $display("FAIL ext_%0d got v=%b i=%h imm=%h rs=%h rt=%h want v=1 i=%h imm=%h rs=%h rt=%h",
                         i, out_valid, out_instr, out_imm, out_rs, out_rt, e.instr, e.imm, e.rs, e.rt);
            end
        end
        drive(1'b0, 16'h0000, 2'd0, 1'b0, 16'h0000, 16'h0000);
        stepClk();
        checks++;
        if ({out_valid, out_instr, out_imm} !== {1'b0, 16'h0800, e.imm}) begin
            failures++;
            $display("FAIL drain got v=%b i=%h imm=%h want v=0 i=0800 imm=%h", out_valid, out_instr, out_imm, e.imm);
        end
    endtask

    task automatic test_stall();
        exp_t e;
        out_ready = 1'b1;
        drive(1'b1, 16'hA123, 2'd1, 1'b1, 16'hAAAA, 16'h5555);
        sbQ.push_back('{16'hA123, refExt(16'hA123, 2'd1, 1'b1), 16'hAAAA, 16'h5555});
        stepClk();
        out_ready = 1'b0;
        drive(1'b1, 16'hB456, 2'd0, 1'b0, 16'hBBBB, 16'h6666);
        for (int c = 0; c < 3; c++) begin
            #1;
            e = sbQ[0];
            checks++;
            if ({out_valid, out_instr, out_imm, out_rs, out_rt, in_ready} !== {1'b1, e, 1'b0}) begin
                failures++;
                $display("FAIL stall_hold_%0d got v=%b i=%h imm=%h rdy=%b want v=1 i=%h imm=%h rdy=0",
                         c, out_valid, out_instr, out_imm, in_ready, e.instr, e.imm);
            end
            stepClk();
        end
        checks++;
        if (stall_cnt !== EXP_STALL) begin
            failures++;
            $display("FAIL stall_cnt got %0d want %0d", stall_cnt, EXP_STALL);
        end
        out_ready = 1'b1;
        void'(sbQ.pop_front());
        sbQ.push_back('{16'hB456, refExt(16'hB456, 2'd0, 1'b0), 16'hBBBB, 16'h6666});
        stepClk();
        e = sbQ.pop_front();
        checks++;
        if ({out_valid, out_instr, out_imm, out_rs, out_rt} !== {1'b1, e}) begin
            failures++;
            $display("FAIL stall_release got v=%b i=%h imm=%h want v=1 i=%h imm=%h",
                     out_valid, out_instr, out_imm, e.instr, e.imm);
        end
        drive(1'b0, 16'h0000, 2'd0, 1'b0, 16'h0000, 16'h0000);
        stepClk();
        checks++;
        if ({out_valid, stall_cnt} !== {1'b0, EXP_STALL}) begin
            failures++;
            $display("FAIL stall_after got v=%b cnt=%0d want v=0 cnt=%0d", out_valid, stall_cnt, EXP_STALL);
        end
    endtask

    task automatic test_flush();
        out_ready = 1'b1;
        drive(1'b1, 16'hC0DE, 2'd2, 1'b1, 16'h1111, 16'h2222);
        stepClk();
        out_ready = 1'b0;
        flush = 1'b1;
        drive(1'b1, 16'hD00D, 2'd0, 1'b1, 16'h3333, 16'h4444);
        stepClk();
        checks++;
        if ({out_valid, out_instr, out_imm, flush_cnt} !== {1'b0, 16'h0800, 16'h0000, EXP_FLUSH}) begin
            failures++;
            $display("FAIL flush got v=%b i=%h imm=%h fcnt=%0d want v=0 i=0800 imm=0 fcnt=%0d",
                     out_valid, out_instr, out_imm, flush_cnt, EXP_FLUSH);
        end
        stepClk();
        checks++;
        if ({out_valid, flush_cnt} !== {1'b0, EXP_FLUSH}) begin
            failures++;
            $display("FAIL flush_empty got v=%b fcnt=%0d want v=0 fcnt=%0d", out_valid, flush_cnt, EXP_FLUSH);
        end
        flush = 1'b0; out_ready = 1'b1;
        drive(1'b0, 16'h0000, 2'd0, 1'b0, 16'h0000, 16'h0000);
        stepClk();
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b1;
        drive(1'b1, 16'hE1E1, 2'd1, 1'b0, 16'h7777, 16'h8888);
        stepClk();
        out_ready = 1'b0;
        stepClk();
        rst_n = 1'b0;
        stepClk();
        rst_n = 1'b1;
        drive(1'b0, 16'h0000, 2'd0, 1'b0, 16'h0000, 16'h0000);
        #1;
        checks++;
        if ({out_valid, out_instr, out_imm, out_rs, out_rt, stall_cnt, flush_cnt, in_ready}
            !== {1'b0, 16'h0800, 80'h0, 1'b1}) begin
            failures++;
            $display("FAIL reset_mid got v=%b i=%h imm=%h rs=%h rt=%h sc=%0d fc=%0d rdy=%b want reset values rdy=1",
                     out_valid, out_instr, out_imm, out_rs, out_rt, stall_cnt, flush_cnt, in_ready);
        end
        out_ready = 1'b1;
        drive(1'b1, 16'hF0F0, 2'd0, 1'b1, 16'h9999, 16'hAAAA);
        stepClk();
        rst_n = 1'b0; flush = 1'b1;
        stepClk();
        rst_n = 1'b1; flush = 1'b0;
        drive(1'b0, 16'h0000, 2'd0, 1'b0, 16'h0000, 16'h0000);
        checks++;
        if ({out_valid, out_instr, out_imm, out_rs, out_rt, flush_cnt} !== {1'b0, 16'h0800, 64'h0}) begin
            failures++;
            $display("FAIL reset_flush got v=%b i=%h imm=%h rs=%h rt=%h fc=%0d want reset values",
                     out_valid, out_instr, out_imm, out_rs, out_rt, flush_cnt);
        end
        stepClk();
    endtask

    task automatic test_back_to_back();
        exp_t        e;
        logic [15:0] ins;
        logic [1:0]  loc;
        logic        sx;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            ins = 16'($urandom());
            loc = 2'($urandom_range(3, 0));
            sx  = 1'($urandom_range(1, 0));
            drive(1'b1, ins, loc, sx, 16'(i * 3), 16'(16'hFF00 + i));
            sbQ.push_back('{ins, refExt(ins, loc, sx), 16'(i * 3), 16'(16'hFF00 + i)});
            stepClk();
            e = sbQ.pop_front();
            checks++;
            if ({out_valid, out_instr, out_imm, out_rs, out_rt} !== {1'b1, e}) begin
                failures++;
                $display("FAIL b2b_%0d got v=%b i=%h imm=%h rs=%h rt=%h want v=1 i=%h imm=%h rs=%h rt=%h",
                         i, out_valid, out_instr, out_imm, out_rs, out_rt, e.instr, e.imm, e.rs, e.rt);
            end
        end
        drive(1'b0, 16'h0000, 2'd0, 1'b0, 16'h0000, 16'h0000);
        stepClk();
        checks++;
        if ({out_valid, out_instr} !== {1'b0, 16'h0800}) begin
            failures++;
            $display("FAIL b2b_drain got v=%b i=%h want v=0 i=0800", out_valid, out_instr);
        end
    endtask

    initial begin
        test_reset();
        test_extension();
        test_stall();
        test_flush();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
